// File: rtl/al_accel_ibuf_seq.sv
// Snake-scan sequencer: fetches input words and drives al_accel_ibuf load/shift/row-change controls.
// Define AL_IBUF_SEQ_PERF_EN to add the perf_stall / perf_loads counters.
module al_accel_ibuf_seq #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_row_words,
    input  logic [CNT_W-1:0]  cfg_n_groups,
    input  logic [CNT_W-1:0]  cfg_n_rows,
    input  logic [2:0]        cfg_tail_wstrb,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ibuf_di,
    output logic              ibuf_ld_wrn,
    output logic [1:0]        ibuf_bank_sel,
    output logic              ibuf_di_revert,
    output logic [2:0]        ibuf_conv_wstrb,
    output logic              ibuf_conv_fi_load,
    output logic              ibuf_conv_se_load,
    output logic              ibuf_enb,
    output logic              busy,
    output logic              done
`ifdef AL_IBUF_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_loads
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DOWN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  r_q, r_d, g_q, g_d;
    logic [1:0]        b_q, b_d;
    logic [2:0]        s_q, s_d;
    logic              dn_q, dn_d;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rw_q, ng_q, nr_q;
    logic [2:0]        tail_q;

    logic              tail_grp, row_end, last_row;
    logic [2:0]        n_shift;
    logic [ADDR_W-1:0] row_sel, fetch_addr;

    // The tail group is always the physical last column group, whatever the sweep direction.
    assign tail_grp   = (g_q == ng_q - CNT_W'(1));
    assign row_end    = r_q[0] ? (g_q == '0) : tail_grp;
    assign last_row   = (r_q == nr_q - CNT_W'(1));
    assign n_shift    = (tail_grp && tail_q != 3'd0) ? tail_q : 3'd4;
    assign row_sel    = ADDR_W'(r_q) + ADDR_W'(b_q) - ADDR_W'(1);
    assign fetch_addr = base_q + row_sel * ADDR_W'(rw_q) + ADDR_W'(g_q);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        s_d     = s_q;
        dn_d    = dn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = '0;
                    g_d     = '0;
                    b_d     = 2'd1;
                    s_d     = 3'd0;
                    dn_d    = 1'b0;
                    state_d = (cfg_n_rows == '0 || cfg_n_groups == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: if (mem_ack) state_d = S_LOAD;
            S_LOAD: begin
                if (b_q != 2'd3) begin
                    b_d     = b_q + 2'd1;
                    state_d = S_FETCH;
                end else begin
                    b_d     = 2'd1;
                    s_d     = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                s_d = s_q + 3'd1;
                if (s_q == n_shift - 3'd1) begin
                    if (!row_end) begin
                        g_d     = r_q[0] ? g_q - CNT_W'(1) : g_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end else if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        dn_d    = 1'b0;
                        state_d = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                dn_d = 1'b1;
                if (dn_q) begin
                    dn_d    = 1'b0;
                    r_d     = r_q + CNT_W'(1);
                    b_d     = 2'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= 2'd0;
            s_q     <= 3'd0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            s_q     <= s_d;
            dn_q    <= dn_d;
        end
    end

    // Configuration is captured once per scan so mid-scan input changes have no effect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q <= '0;
            rw_q   <= '0;
            ng_q   <= '0;
            nr_q   <= '0;
            tail_q <= 3'd0;
            data_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                base_q <= cfg_base;
                rw_q   <= cfg_row_words;
                ng_q   <= cfg_n_groups;
                nr_q   <= cfg_n_rows;
                tail_q <= cfg_tail_wstrb;
            end
            if (state_q == S_FETCH && mem_ack) data_q <= mem_rdata;
        end
    end

    assign mem_req           = (state_q == S_FETCH);
    assign mem_addr          = mem_req ? fetch_addr : '0;
    assign ibuf_ld_wrn       = (state_q == S_LOAD);
    assign ibuf_bank_sel     = ibuf_ld_wrn ? b_q : 2'd0;
    assign ibuf_di           = ibuf_ld_wrn ? data_q : 32'd0;
    assign ibuf_conv_wstrb   = (ibuf_ld_wrn && tail_grp) ? tail_q : 3'd0;
    assign busy              = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                               (state_q == S_SHIFT) || (state_q == S_DOWN);
    assign ibuf_di_revert    = busy && r_q[0];
    assign ibuf_conv_se_load = (state_q == S_DOWN);
    assign ibuf_conv_fi_load = (state_q == S_DOWN) && dn_q;
    assign ibuf_enb          = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_DOWN);
    assign done              = (state_q == S_DONE);

`ifdef AL_IBUF_SEQ_PERF_EN
    logic [31:0] stall_q, loads_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
            loads_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
            loads_q <= '0;
        end else begin
            if (state_q == S_FETCH && !mem_ack && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (state_q == S_LOAD && loads_q != '1) loads_q <= loads_q + 32'd1;
        end
    end

    assign perf_stall = stall_q;
    assign perf_loads = loads_q;
`endif

endmodule

// File: tb/tb_al_accel_ibuf_seq.sv
// Directed bench for al_accel_ibuf_seq: per-cycle event trace compared against hand-derived sequences.
module tb_al_accel_ibuf_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [7:0]  cfg_row_words = '0, cfg_n_groups = '0, cfg_n_rows = '0;
    logic [2:0]  cfg_tail_wstrb = '0;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata, ibuf_di;
    logic        ibuf_ld_wrn, ibuf_di_revert, ibuf_conv_fi_load, ibuf_conv_se_load, ibuf_enb;
    logic [1:0]  ibuf_bank_sel;
    logic [2:0]  ibuf_conv_wstrb;
    logic        busy, done;
`ifdef AL_IBUF_SEQ_PERF_EN
    logic [31:0] perf_stall, perf_loads;
`endif

    int checks = 0;
    int errors = 0;

    al_accel_ibuf_seq #(.ADDR_W(16), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .cfg_base(cfg_base), .cfg_row_words(cfg_row_words), .cfg_n_groups(cfg_n_groups),
        .cfg_n_rows(cfg_n_rows), .cfg_tail_wstrb(cfg_tail_wstrb),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ibuf_di(ibuf_di), .ibuf_ld_wrn(ibuf_ld_wrn), .ibuf_bank_sel(ibuf_bank_sel),
        .ibuf_di_revert(ibuf_di_revert), .ibuf_conv_wstrb(ibuf_conv_wstrb),
        .ibuf_conv_fi_load(ibuf_conv_fi_load), .ibuf_conv_se_load(ibuf_conv_se_load),
        .ibuf_enb(ibuf_enb), .busy(busy), .done(done)
`ifdef AL_IBUF_SEQ_PERF_EN
        , .perf_stall(perf_stall), .perf_loads(perf_loads)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: word content is {~addr, addr}; ack after ack_delay wait cycles.
    logic ack_en = 1'b1, ack_force = 1'b0;
    int   ack_delay = 0;
    int   wcnt = 0;
    assign mem_rdata = {~mem_addr, mem_addr};
    assign mem_ack   = ack_en ? (mem_req && wcnt == ack_delay) : ack_force;
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    logic [60:0] all_o;
    assign all_o = {mem_req, mem_addr, ibuf_di, ibuf_ld_wrn, ibuf_bank_sel, ibuf_di_revert,
                    ibuf_conv_wstrb, ibuf_conv_fi_load, ibuf_conv_se_load, ibuf_enb, busy, done};

    // Event trace: W=fetch wait, A=fetch acked, L=load, S=shift, 1/2=row-change cycles, E=done, X=stray bank_sel
    logic        rec = 1'b0;
    string       trace;
    logic [15:0] req_q[$], ack_q[$];
    logic [31:0] di_q[$];
    logic [1:0]  bank_q[$];
    logic [2:0]  ws_q[$];
    logic        rev_q[$];

    always @(negedge clk) begin
        if (rec) begin
            if (mem_req) begin
                req_q.push_back(mem_addr);
                if (mem_ack) begin
                    trace = {trace, "A"};
                    ack_q.push_back(mem_addr);
                end else trace = {trace, "W"};
            end
            if (ibuf_ld_wrn) begin
                trace = {trace, "L"};
                di_q.push_back(ibuf_di);
                bank_q.push_back(ibuf_bank_sel);
                ws_q.push_back(ibuf_conv_wstrb);
                rev_q.push_back(ibuf_di_revert);
            end else if (ibuf_conv_fi_load && ibuf_conv_se_load) trace = {trace, "2"};
            else if (ibuf_conv_se_load) trace = {trace, "1"};
            else if (ibuf_enb) trace = {trace, "S"};
            if (done) trace = {trace, "E"};
            if (!ibuf_ld_wrn && ibuf_bank_sel != 2'd0) trace = {trace, "X"};
        end
    end

    task automatic clear_rec();
        trace = "";
        req_q.delete(); ack_q.delete(); di_q.delete();
        bank_q.delete(); ws_q.delete(); rev_q.delete();
    endtask

    task automatic run_scan(input logic [15:0] base, input logic [7:0] rw, input logic [7:0] ng,
                            input logic [7:0] nr, input logic [2:0] tail, input int delay,
                            input int restart_at, output bit timed_out, output int done_at);
        clear_rec();
        cfg_base = base; cfg_row_words = rw; cfg_n_groups = ng; cfg_n_rows = nr;
        cfg_tail_wstrb = tail; ack_en = 1'b1; ack_delay = delay; rec = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // Scramble config after capture; the scan must not notice.
        cfg_base = 16'hDEAD; cfg_row_words = 8'h77; cfg_n_groups = 8'h9; cfg_n_rows = 8'h9;
        timed_out = 1'b1;
        done_at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            if (done) begin
                timed_out = 1'b0;
                done_at = i;
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        rec = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (all_o !== 61'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_o);
        end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_reset_midfetch();
        clear_rec();
        cfg_base = 16'h300; cfg_row_words = 8'd1; cfg_n_groups = 8'd1; cfg_n_rows = 8'd1;
        cfg_tail_wstrb = 3'd0; ack_en = 1'b0; ack_force = 1'b0; rec = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h300) begin
            errors++;
            $display("FAIL midfetch_req: got req=%b addr=%h expected req=1 addr=0300", mem_req, mem_addr);
        end
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (all_o !== 61'd0) begin
            errors++;
            $display("FAIL midfetch_reset_outputs: got %h expected 0", all_o);
        end
        resetn = 1'b1;
        @(negedge clk); ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        rec = 1'b0;
        ack_en = 1'b1;
        checks++;
        if (trace != "WW") begin
            errors++;
            $display("FAIL midfetch_trace: got '%s' expected 'WW'", trace);
        end
        checks++;
        if (all_o !== 61'd0) begin
            errors++;
            $display("FAIL late_ack_outputs: got %h expected 0", all_o);
        end
    endtask

    task automatic test_one_row();
        bit to; int da;
        logic [15:0] ea [6];
        ea = '{16'h100, 16'h108, 16'h110, 16'h101, 16'h109, 16'h111};
        run_scan(16'h100, 8'd8, 8'd2, 8'd1, 3'd0, 0, -1, to, da);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL one_row_timeout: done not seen"); end
        checks++;
        if (trace != "ALALALSSSSALALALSSSSE") begin
            errors++;
            $display("FAIL one_row_trace: got '%s' expected 'ALALALSSSSALALALSSSSE'", trace);
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a; logic [1:0] bk; logic rv;
            a  = (ack_q.size() > i) ? ack_q[i] : 16'hxxxx;
            bk = (bank_q.size() > i) ? bank_q[i] : 2'bxx;
            rv = (rev_q.size() > i) ? rev_q[i] : 1'bx;
            checks++;
            if (a !== ea[i] || bk !== 2'(i % 3 + 1) || rv !== 1'b0) begin
                errors++;
                $display("FAIL one_row_load%0d: got addr=%h bank=%0d rev=%b expected addr=%h bank=%0d rev=0",
                         i, a, bk, rv, ea[i], i % 3 + 1);
            end
        end
    endtask

    task automatic test_two_rows();
        bit to; int da;
        logic [15:0] ea [12];
        ea = '{16'h100, 16'h108, 16'h110, 16'h101, 16'h109, 16'h111,
               16'h109, 16'h111, 16'h119, 16'h108, 16'h110, 16'h118};
        run_scan(16'h100, 8'd8, 8'd2, 8'd2, 3'd0, 0, -1, to, da);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL two_rows_timeout: done not seen"); end
        checks++;
        if (trace != "ALALALSSSSALALALSSSS12ALALALSSSSALALALSSSSE") begin
            errors++;
            $display("FAIL two_rows_trace: got '%s' expected 'ALALALSSSSALALALSSSS12ALALALSSSSALALALSSSSE'", trace);
        end
        for (int i = 0; i < 12; i++) begin
            logic [15:0] a; logic rv;
            a  = (ack_q.size() > i) ? ack_q[i] : 16'hxxxx;
            rv = (rev_q.size() > i) ? rev_q[i] : 1'bx;
            checks++;
            if (a !== ea[i] || rv !== (i >= 6)) begin
                errors++;
                $display("FAIL two_rows_load%0d: got addr=%h rev=%b expected addr=%h rev=%0d",
                         i, a, rv, ea[i], i >= 6);
            end
        end
    endtask

    task automatic test_tail();
        bit to; int da;
        logic [15:0] ea [6];
        ea = '{16'h200, 16'h204, 16'h208, 16'h201, 16'h205, 16'h209};
        run_scan(16'h200, 8'd4, 8'd2, 8'd1, 3'd3, 0, -1, to, da);
        checks++;
        if (trace != "ALALALSSSSALALALSSSE") begin
            errors++;
            $display("FAIL tail_trace: got '%s' expected 'ALALALSSSSALALALSSSE'", trace);
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a; logic [2:0] w;
            a = (ack_q.size() > i) ? ack_q[i] : 16'hxxxx;
            w = (ws_q.size() > i) ? ws_q[i] : 3'bxxx;
            checks++;
            if (a !== ea[i] || w !== ((i >= 3) ? 3'd3 : 3'd0)) begin
                errors++;
                $display("FAIL tail_load%0d: got addr=%h wstrb=%0d expected addr=%h wstrb=%0d",
                         i, a, w, ea[i], (i >= 3) ? 3 : 0);
            end
        end
    endtask

    task automatic test_wait_states();
        bit to; int da;
        logic [15:0] ea [3];
        ea = '{16'h040, 16'h050, 16'h060};
        run_scan(16'h040, 8'h10, 8'd1, 8'd1, 3'd0, 5, -1, to, da);
        checks++;
        if (trace != "WWWWWALWWWWWALWWWWWALSSSSE") begin
            errors++;
            $display("FAIL wait_trace: got '%s' expected 'WWWWWALWWWWWALWWWWWALSSSSE'", trace);
        end
        checks++;
        if (req_q.size() !== 18) begin
            errors++;
            $display("FAIL wait_req_cycles: got %0d expected 18", req_q.size());
        end
        for (int i = 0; i < 18 && i < req_q.size(); i++) begin
            checks++;
            if (req_q[i] !== ea[i / 6]) begin
                errors++;
                $display("FAIL wait_addr_hold%0d: got %h expected %h", i, req_q[i], ea[i / 6]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = (di_q.size() > i) ? di_q[i] : 32'hxxxxxxxx;
            checks++;
            if (d !== {~ea[i], ea[i]}) begin
                errors++;
                $display("FAIL wait_di%0d: got %h expected %h", i, d, {~ea[i], ea[i]});
            end
        end
`ifdef AL_IBUF_SEQ_PERF_EN
        checks++;
        if (perf_stall !== 32'd15 || perf_loads !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts: got stall=%0d loads=%0d expected stall=15 loads=3", perf_stall, perf_loads);
        end
`endif
    endtask

    task automatic test_empty_and_restart();
        bit to; int da;
        run_scan(16'h010, 8'd4, 8'd3, 8'd0, 3'd0, 0, -1, to, da);
        checks++;
        if (to !== 1'b0 || da !== 0 || trace != "E") begin
            errors++;
            $display("FAIL empty_scan: got to=%0d done_at=%0d trace='%s' expected to=0 done_at=0 trace='E'", to, da, trace);
        end
        run_scan(16'h020, 8'd2, 8'd1, 8'd1, 3'd0, 0, 3, to, da);
        checks++;
        if (to !== 1'b0 || trace != "ALALALSSSSE") begin
            errors++;
            $display("FAIL restart_ignored: got to=%0d trace='%s' expected to=0 trace='ALALALSSSSE'", to, trace);
        end
    endtask

    task automatic test_single_group_rows();
        bit to; int da;
        run_scan(16'h000, 8'd1, 8'd1, 8'd2, 3'd2, 0, -1, to, da);
        checks++;
        if (trace != "ALALALSS12ALALALSSE") begin
            errors++;
            $display("FAIL single_group_trace: got '%s' expected 'ALALALSS12ALALALSSE'", trace);
        end
        checks++;
        if (ack_q.size() !== 6 || ack_q[3] !== 16'h001 || rev_q[3] !== 1'b1 || ws_q[3] !== 3'd2) begin
            errors++;
            $display("FAIL single_group_row1: got n=%0d addr=%h rev=%b ws=%0d expected n=6 addr=0001 rev=1 ws=2",
                     ack_q.size(), ack_q.size() > 3 ? ack_q[3] : 16'hxxxx,
                     rev_q.size() > 3 ? rev_q[3] : 1'bx, ws_q.size() > 3 ? ws_q[3] : 3'bxxx);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midfetch();
        test_one_row();
        test_two_rows();
        test_tail();
        test_wait_states();
        test_empty_and_restart();
        test_single_group_rows();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
